// File: rtl/rv_fetch_decode_exec.sv
// Purpose : single-cycle RV32I core (fetch, decode, execute, writeback) with PC, regfile and data RAM.
// Latency : one instruction retires per clk; register, data-RAM and debug reads are combinational.
// Backpr. : none; the core never stalls and fetches from imem_addr every cycle.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset (pc, x1..x31 cleared; data RAM kept)
//   imem_addr      byte address of the current instruction (always equal to pc)
//   imem_rdata     instruction word at imem_addr, combinational from the external ROM
//   instruction    instruction being executed this cycle
//   pc             current program counter
//   dbg_reg_addr   debug read index into the register file
//   dbg_reg_data   x[dbg_reg_addr], combinational, 0 for x0
module rv_fetch_decode_exec #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    // Decode fields
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imem_addr   = pc;
    assign instruction = imem_rdata;

    assign opcode    = instruction[6:0];
    assign rd        = instruction[11:7];
    assign funct3    = instruction[14:12];
    assign rs1       = instruction[19:15];
    assign rs2       = instruction[24:20];
    assign funct7_b5 = instruction[30];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Register reads see pre-edge state, so rd==rs1 forms (e.g. JALR x1,x1) are safe.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val      = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val      = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : regs[dbg_reg_addr];

    // ALU: OP uses rs2, OP-IMM uses immI; SUB only exists in the register form.
    logic [31:0] alu_b, alu_res;
    logic [4:0]  shamt;
    always_comb begin
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_res = 32'd0;
        case (funct3)
            3'b000:  alu_res = (opcode == OPC_OP && funct7_b5) ? rs1_val - alu_b
                                                                : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = funct7_b5 ? 32'($signed(rs1_val) >>> shamt)
                                         : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch condition
    logic br_take;
    always_comb begin
        br_take = 1'b0;
        case (funct3)
            3'b000:  br_take = (rs1_val == rs2_val);
            3'b001:  br_take = (rs1_val != rs2_val);
            3'b100:  br_take = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_take = (rs1_val <  rs2_val);
            3'b111:  br_take = (rs1_val >= rs2_val);
            default: br_take = 1'b0;
        endcase
    end

    // Data RAM access: one shared address adder for loads and stores.
    // Address bits above the RAM depth are ignored, so accesses wrap.
    logic [31:0]    mem_addr, ld_word, ld_val, st_data;
    logic [DAW-1:0] mem_idx;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [3:0]     st_be;
    logic           st_we;
    logic           unused_bits;

    assign mem_addr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign mem_idx     = mem_addr[DAW+1:2];
    assign ld_word     = dmem[mem_idx];
    assign ld_byte     = ld_word[{mem_addr[1:0], 3'b000} +: 8];
    assign ld_half     = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    assign unused_bits = ^mem_addr[31:DAW+2];

    always_comb begin
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        st_data = rs2_val;
        st_be   = 4'b0000;
        case (funct3)
            3'b000: begin
                st_data = {4{rs2_val[7:0]}};
                st_be   = 4'b0001 << mem_addr[1:0];
            end
            3'b001: begin
                st_data = {2{rs2_val[15:0]}};
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010:  st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    // Next PC and writeback selection. Unknown opcodes, FENCE and SYSTEM fall to NOP.
    logic [31:0] pc_plus4, next_pc, rd_val;
    logic        rd_we;
    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        rd_we    = 1'b0;
        rd_val   = alu_res;
        st_we    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OPC_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (br_take) begin
                    next_pc = pc + imm_b;
                end
            end
            OPC_LOAD: begin
                rd_we  = 1'b1;
                rd_val = ld_val;
            end
            OPC_STORE: st_we = ~rst;
            OPC_OP, OPC_OPIMM: rd_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) begin
                regs[rd] <= rd_val;
            end
        end
    end

    // Data RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    dmem[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_decode_exec.sv
`timescale 1ns/100ps
module tb_rv_fetch_decode_exec;
    localparam int K_PC  = 0;
    localparam int K_REG = 1;
    localparam int K_INS = 2;

    typedef struct {
        int          at;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr, imem_rdata, instruction, pc, dbg_reg_data;
    logic [4:0]  dbg_reg_addr;

    logic [31:0] imem [0:31];
    int          edge_n = 0;
    exp_t        exp_q[$];
    bit          done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    assign imem_rdata = imem[imem_addr[6:2]];

    rv_fetch_decode_exec #(
        .RESET_PC  (32'h0000_0000),
        .DMEM_WORDS(256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_data(dbg_reg_data)
    );

    task automatic push(input int at, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Stimulus: program ROM, resets, and the expected architectural state after each edge.
    initial begin
        int base;
        for (int i = 0; i < 32; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'hFFF0_0093; // 0x00 ADDI x1,x0,-1
        imem[1]  = 32'h0040_D113; // 0x04 SRLI x2,x1,4
        imem[2]  = 32'h4040_D193; // 0x08 SRAI x3,x1,4
        imem[3]  = 32'h0010_3233; // 0x0C SLTU x4,x0,x1
        imem[4]  = 32'h1234_5337; // 0x10 LUI x6,0x12345
        imem[5]  = 32'h0000_1297; // 0x14 AUIPC x5,0x1
        imem[6]  = 32'h0050_0013; // 0x18 ADDI x0,x0,5
        imem[7]  = 32'h0000_0073; // 0x1C ECALL
        imem[8]  = 32'h0000_C463; // 0x20 BLT x1,x0,+8
        imem[9]  = 32'h0630_0393; // 0x24 ADDI x7,x0,99 (skipped)
        imem[10] = 32'h0000_E463; // 0x28 BLTU x1,x0,+8
        imem[11] = 32'h0080_07EF; // 0x2C JAL x15,+8
        imem[12] = 32'h04D0_0393; // 0x30 ADDI x7,x0,77 (skipped)
        imem[13] = 32'h8899_B437; // 0x34 LUI x8,0x8899B
        imem[14] = 32'hABB4_0413; // 0x38 ADDI x8,x8,-0x545
        imem[15] = 32'h0100_0493; // 0x3C ADDI x9,x0,0x10
        imem[16] = 32'h0084_A023; // 0x40 SW x8,0(x9)
        imem[17] = 32'h0014_8503; // 0x44 LB x10,1(x9)
        imem[18] = 32'h0024_D583; // 0x48 LHU x11,2(x9)
        imem[19] = 32'h0550_0613; // 0x4C ADDI x12,x0,0x55
        imem[20] = 32'h00C4_81A3; // 0x50 SB x12,3(x9)
        imem[21] = 32'h0004_A683; // 0x54 LW x13,0(x9)
        imem[22] = 32'h4053_0833; // 0x58 SUB x16,x6,x5
        imem[23] = 32'h0064_48B3; // 0x5C XOR x17,x8,x6
        imem[24] = 32'h0004_9463; // 0x60 BNE x9,x0,+8
        imem[25] = 32'h0630_0393; // 0x64 ADDI x7,x0,99 (skipped)
        imem[26] = 32'h0210_0093; // 0x68 ADDI x1,x0,0x21
        imem[27] = 32'h0010_80E7; // 0x6C JALR x1,x1,1

        // Power-on reset
        #1 rst = 1'b1;
        push(0, K_PC, 0, 32'h0);
        push(0, K_REG, 1, 32'h0);
        push(0, K_INS, 0, 32'hFFF0_0093);
        repeat (3) @(negedge clk);
        #6 rst = 1'b0;
        base = edge_n;

        // Phase A: run to pc=0x40, then reset mid-run
        push(base + 14, K_PC, 0, 32'h40);
        push(base + 14, K_REG, 5, 32'h0000_1014);
        while (edge_n < base + 14) @(negedge clk);
        #6 rst = 1'b1;
        push(edge_n, K_PC, 0, 32'h0);
        push(edge_n, K_REG, 5, 32'h0);
        push(edge_n, K_INS, 0, 32'hFFF0_0093);
        push(edge_n + 1, K_PC, 0, 32'h0);
        push(edge_n + 1, K_REG, 1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #6 rst = 1'b0;
        base = edge_n;

        // Phase B: full program from RESET_PC
        push(base + 1,  K_PC,  0,  32'h4);
        push(base + 1,  K_REG, 1,  32'hFFFF_FFFF);
        push(base + 2,  K_REG, 2,  32'h0FFF_FFFF);
        push(base + 3,  K_REG, 3,  32'hFFFF_FFFF);
        push(base + 4,  K_REG, 4,  32'h1);
        push(base + 5,  K_REG, 6,  32'h1234_5000);
        push(base + 6,  K_REG, 5,  32'h0000_1014);
        push(base + 7,  K_REG, 0,  32'h0);
        push(base + 7,  K_PC,  0,  32'h1C);
        push(base + 8,  K_PC,  0,  32'h20);
        push(base + 8,  K_REG, 6,  32'h1234_5000);
        push(base + 9,  K_PC,  0,  32'h28);
        push(base + 10, K_PC,  0,  32'h2C);
        push(base + 11, K_PC,  0,  32'h34);
        push(base + 11, K_REG, 15, 32'h30);
        push(base + 12, K_REG, 8,  32'h8899_B000);
        push(base + 13, K_REG, 8,  32'h8899_AABB);
        push(base + 14, K_REG, 9,  32'h10);
        push(base + 15, K_PC,  0,  32'h44);
        push(base + 16, K_REG, 10, 32'hFFFF_FFAA);
        push(base + 17, K_REG, 11, 32'h0000_8899);
        push(base + 18, K_REG, 12, 32'h55);
        push(base + 19, K_PC,  0,  32'h54);
        push(base + 20, K_REG, 13, 32'h5599_AABB);
        push(base + 21, K_REG, 16, 32'h1234_3FEC);
        push(base + 22, K_REG, 17, 32'h9AAD_FABB);
        push(base + 23, K_PC,  0,  32'h68);
        push(base + 24, K_REG, 1,  32'h21);
        push(base + 25, K_PC,  0,  32'h22);
        push(base + 25, K_REG, 1,  32'h70);
        push(base + 25, K_REG, 7,  32'h0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        #5 done = 1'b1;
    end

    // Monitor: pops expectations whose cycle has arrived and compares DUT outputs.
    initial begin
        exp_t        e;
        logic [31:0] act;
        bit          bad;
        string       nm;
        dbg_reg_addr = 5'd0;
        forever begin
            @(negedge clk or posedge rst or posedge done);
            #1;
            while (exp_q.size() != 0 && exp_q[0].at <= edge_n) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_PC: begin
                        nm  = "pc";
                        act = pc;
                        bad = (pc !== e.val) || (imem_addr !== e.val);
                    end
                    K_REG: begin
                        nm = $sformatf("x%0d", e.idx);
                        dbg_reg_addr = 5'(e.idx);
                        #0.5;
                        act = dbg_reg_data;
                        bad = (act !== e.val);
                    end
                    default: begin
                        nm  = "instruction";
                        act = instruction;
                        bad = (act !== e.val);
                    end
                endcase
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got %08h (imem_addr %08h), expected %08h",
                             nm, e.at, act, imem_addr, e.val);
                end
            end
            if (done) begin
                while (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL timeout: expectation for cycle %0d (kind %0d idx %0d) never reached",
                             e.at, e.kind, e.idx);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

endmodule
